circle_chase_ctrl: RTL

//   Sequences a "circle chaser" animation across NUM_DIGITS seven-segment digits.

---
 rtl/circle_chase_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/circle_chase_ctrl.sv
// Circle-chaser sequencer: moves one lit circle around the upper/lower rows of a
// chain of seven-segment digits, with run/hold/single-step control and a lap pulse.
//
// state | meaning
// IDLE  | animation off, all digits dark, pos parked at 0
// RUN   | prescaler free-running, pos advances once every TICK_DIV clocks
// HOLD  | frozen at current pos, single steps accepted
module circle_chase_ctrl #(
   parameter int NUM_DIGITS = 4,
   parameter int TICK_DIV   = 25_000_000,
   localparam int PW        = (2*NUM_DIGITS > 1) ? $clog2(2*NUM_DIGITS) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  step,
   input  logic                  dir,
   output logic [NUM_DIGITS-1:0] digit_en,
   output logic [NUM_DIGITS-1:0] digit_row,
   output logic [PW-1:0]         pos,
   output logic                  wrap,
   output logic                  busy
);

   localparam int            CW   = $clog2(TICK_DIV);
   localparam logic [CW-1:0] TC   = CW'(TICK_DIV - 1);
   localparam logic [PW-1:0] LAST = PW'(2*NUM_DIGITS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   pos_q, pos_d;
   logic [CW-1:0]   presc_q, presc_d;
   logic            wrap_q, wrap_d;
   logic            adv;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pos_q   <= '0;
         presc_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
         presc_q <= presc_d;
         wrap_q  <= wrap_d;
      end
   end

   // stop outranks start, start outranks step; prescaler only counts in RUN
   always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      presc_d = '0;
      wrap_d  = 1'b0;
      adv     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!stop && start) begin
               state_d = RUN;
               pos_d   = '0;
            end
         end
         RUN: begin
            if (stop) begin
               state_d = HOLD;
            end else if (presc_q == TC) begin
               adv = 1'b1;
            end else begin
               presc_d = presc_q + CW'(1);
            end
         end
         HOLD: begin
            if (stop) begin
               state_d = IDLE;
               pos_d   = '0;
            end else if (start) begin
               state_d = RUN;
            end else if (step) begin
               adv = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (adv) begin
         if (dir) begin
            pos_d  = (pos_q == '0) ? LAST : pos_q - PW'(1);
            wrap_d = (pos_q == '0);
         end else begin
            pos_d  = (pos_q == LAST) ? '0 : pos_q + PW'(1);
            wrap_d = (pos_q == LAST);
         end
      end
   end

   // Upper row runs left-to-right on pos 0..N-1, lower row folds back on N..2N-1
   always_comb begin
      digit_en  = '0;
      digit_row = '0;
      if (state_q != IDLE) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (pos_q == PW'(i)) begin
               digit_en[i]  = 1'b1;
               digit_row[i] = 1'b1;
            end
            if (pos_q == PW'(2*NUM_DIGITS - 1 - i)) begin
               digit_en[i] = 1'b1;
            end
         end
      end
   end

   assign pos  = pos_q;
   assign wrap = wrap_q;
   assign busy = (state_q != IDLE);

endmodule
